fetch_stage: RTL
================

FETCH_STAGE -- requirements
Module: fetch_stage

Parameters
REQ-001 The block SHALL have parameter NOP_WORD, default 32'h00000000, the instruction word presented when the IF/ID register is empty or flushed.

Interface
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, reset; asynchronous, active-high.
REQ-004 The block SHALL have port pc_in, input, 32, fetch address from the PC stage.
REQ-005 The block SHALL have port pc_active, input, 1, PC stage active; fetch permitted.
REQ-006 The block SHALL have port decode_stall, input, 1, decode cannot accept a new instruction this cycle.
REQ-007 The block SHALL have port flush, input, 1, kill IF/ID contents (taken jump/branch redirect).
REQ-008 The block SHALL have port imem_addr, output, 32, instruction memory word address.
REQ-009 The block SHALL have port imem_read, output, 1, instruction memory read request.
REQ-010 The block SHALL have port imem_waitrequest, input, 1, memory not ready; request held.
REQ-011 The block SHALL have port imem_readdata, input, 32, read data, valid when imem_read=1 and imem_waitrequest=0.
REQ-012 The block SHALL have port instr_out, output, 32, IF/ID instruction.
REQ-013 The block SHALL have port pc_plus4_out, output, 32, IF/ID fetch address + 4.
REQ-014 The block SHALL have port valid_out, output, 1, IF/ID holds a live instruction.
REQ-015 The block SHALL have port fetch_busy, output, 1, combinational stall request to the PC stage; PC holds while 1.

Function
REQ-016 The block SHALL implement FSM states IDLE, FETCH, HOLD.
REQ-017 In IDLE: imem_read=0, fetch_busy=0; pc_active=1 -> FETCH next edge; IF/ID valid_out<=0 each edge while idle.
REQ-018 In FETCH: imem_read=1, imem_addr=pc_in combinationally; imem_waitrequest=1 -> fetch_busy=1, stay FETCH, imem_addr held stable by PC stall.
REQ-019 In FETCH, completion with decode_stall=0: fetch_busy=0; next edge instr_out<=imem_readdata, pc_plus4_out<=pc_in+4, valid_out<=1; stay FETCH (one instruction per cycle at zero wait).
REQ-020 In FETCH, completion with decode_stall=1: fetch_busy=1; word and address captured into hold buffer; IF/ID unchanged; -> HOLD.
REQ-021 In HOLD: imem_read=0, fetch_busy=1; when decode_stall=0, next edge hold buffer -> IF/ID (valid_out<=1), -> FETCH.
REQ-022 Decode stall in FETCH with no completion: IF/ID SHALL hold its contents unchanged.
REQ-023 pc_in=0 or pc_active=0 in FETCH/HOLD: FETCH -> IDLE after any in-flight request completes; HOLD contents retained until drained.
REQ-024 pc_plus4_out SHALL be 32-bit modulo: 32'hFFFFFFFC -> 32'h00000000.
REQ-025 Flush SHALL have priority over decode_stall: next edge instr_out<=NOP_WORD, valid_out<=0, hold buffer discarded, HOLD -> FETCH.
REQ-026 Flush while imem_waitrequest=1: set drop flag; the completing word SHALL be discarded (no IF/ID write), flag cleared on that completion; fetch_busy follows REQ-018.
REQ-027 Flush coincident with completion (waitrequest=0) SHALL discard that word; no drop flag set.

Reset
REQ-028 On rst=1, asynchronously: state=IDLE, instr_out=NOP_WORD, pc_plus4_out=0, valid_out=0, hold buffer cleared, drop flag=0; imem_read=0, fetch_busy=0 while rst=1.
REQ-029 Reset mid-request SHALL abandon the request; no IF/ID write from it after release.

Verification
REQ-030 Zero-wait stream: pc_in 0xBFC00000, 0xBFC00004, waitrequest=0, readdata 0x24080005, 0x24090003 -> instr_out sequence 0x24080005, 0x24090003 on consecutive cycles, pc_plus4_out 0xBFC00004, 0xBFC00008, fetch_busy=0 throughout.
REQ-031 Wait states: waitrequest=1 for 3 cycles at 0xBFC00000 -> fetch_busy=1 for 3 cycles, imem_addr stable, single IF/ID write of readdata after completion.
REQ-032 Decode stall: completion with decode_stall=1 for 2 cycles -> HOLD, fetch_busy=1, IF/ID unchanged, word delivered on the edge after decode_stall drops.
REQ-033 Flush in flight: flush pulse during waitrequest=1 -> valid_out=0, instr_out=NOP_WORD; returned word never appears; next fetch delivers normally.
REQ-034 Wrap and reset: pc_in 0xFFFFFFFC -> pc_plus4_out 0x00000000; rst asserted mid-wait -> all outputs reset values immediately, no spurious valid_out after release.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction fetch stage: issues imem reads at pc_in and fills the IF/ID register.
// Latency: one cycle from read completion (waitrequest=0) to IF/ID valid; zero-wait streams one word per cycle.
// Backpressure: fetch_busy holds the PC on memory wait or decode stall; a stalled word parks in a one-entry hold buffer.
module fetch_stage #(
  parameter logic [31:0] NOP_WORD = 32'h00000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_in,
  input  logic        pc_active,
  input  logic        decode_stall,
  input  logic        flush,
  output logic [31:0] imem_addr,
  output logic        imem_read,
  input  logic        imem_waitrequest,
  input  logic [31:0] imem_readdata,
  output logic [31:0] instr_out,
  output logic [31:0] pc_plus4_out,
  output logic        valid_out,
  output logic        fetch_busy
);

  typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;

  state_t      state_q;
  logic        drop_q;        // a flushed request is still in flight; its word must be thrown away
  logic [31:0] hold_instr_q;
  logic [31:0] hold_pc4_q;

  // PC stage has stopped or parked at address zero: wind down once the bus is quiet
  logic stop_req;
  assign stop_req = !pc_active || (pc_in == 32'h0);

  // Memory request and PC stall request; both forced low while reset is held
  always_comb begin
    imem_addr  = pc_in;
    imem_read  = 1'b0;
    fetch_busy = 1'b0;
    if (!rst) begin
      case (state_q)
        FETCH: begin
          imem_read  = 1'b1;
          // A completing word that decode cannot take (and that is not being killed) parks in HOLD
          fetch_busy = imem_waitrequest | (decode_stall & ~flush & ~drop_q);
        end
        HOLD:    fetch_busy = 1'b1;
        default: fetch_busy = 1'b0;
      endcase
    end
  end

  // Fetch FSM, IF/ID register, hold buffer and drop flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      drop_q       <= 1'b0;
      hold_instr_q <= 32'h0;
      hold_pc4_q   <= 32'h0;
      instr_out    <= NOP_WORD;
      pc_plus4_out <= 32'h0;
      valid_out    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          valid_out <= 1'b0;
          if (flush) instr_out <= NOP_WORD;
          if (pc_active) state_q <= FETCH;
        end

        FETCH: begin
          if (flush) begin
            instr_out <= NOP_WORD;
            valid_out <= 1'b0;
            // Still waiting: remember to discard the word when it finally arrives
            drop_q    <= imem_waitrequest;
            if (!imem_waitrequest && stop_req) state_q <= IDLE;
          end else if (!imem_waitrequest) begin
            drop_q <= 1'b0;
            if (!drop_q && decode_stall) begin
              hold_instr_q <= imem_readdata;
              hold_pc4_q   <= pc_in + 32'd4;
              state_q      <= HOLD;
            end else begin
              if (!drop_q) begin
                instr_out    <= imem_readdata;
                pc_plus4_out <= pc_in + 32'd4;
                valid_out    <= 1'b1;
              end else if (!decode_stall) begin
                valid_out <= 1'b0;
              end
              if (stop_req) state_q <= IDLE;
            end
          end else if (!decode_stall) begin
            // Decode consumed the current word and nothing new arrived: insert a bubble
            valid_out <= 1'b0;
          end
        end

        HOLD: begin
          if (flush) begin
            instr_out    <= NOP_WORD;
            valid_out    <= 1'b0;
            hold_instr_q <= 32'h0;
            hold_pc4_q   <= 32'h0;
            state_q      <= stop_req ? IDLE : FETCH;
          end else if (!decode_stall) begin
            instr_out    <= hold_instr_q;
            pc_plus4_out <= hold_pc4_q;
            valid_out    <= 1'b1;
            state_q      <= stop_req ? IDLE : FETCH;
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
